cnt_modctl: RTL and testbench
=============================

Name: cnt_modctl

Overview:
- Control stage that sits directly upstream of the 4-bit presettable synchronous counter (x74161-style: PE active-low parallel load, CEP/CET count enables).
- Drives the counter's PE, CEP, CET and D inputs and watches its Q, so the pair forms a programmable divide-by-N (N = 1..16) with start, stop and pause control.
- Reports each completed period as a one-cycle pulse and keeps a saturating count of completed periods.

Parameters:
- CW, 8, width of the completed-period counter PCNT.

Ports:
- CP  input  1  clock; all state updates on its rising edge.
- CR  input  1  asynchronous active-low reset.
- START  input  1  level; begin counting; sampled only in IDLE.
- STOP  input  1  level; abort to IDLE from any non-IDLE state.
- PAUSE  input  1  level; while high, the counter holds.
- MOD  input  4  modulus; 0 encodes 16, 1..15 literal; captured at START.
- Q_IN  input  4  counter's current Q.
- PE  output  1  to counter PE; active-low parallel load.
- CEP  output  1  to counter CEP.
- CET  output  1  to counter CET.
- D  output  4  to counter D; the preset value.
- BUSY  output  1  high whenever state is not IDLE.
- PERIOD  output  1  registered one-cycle pulse per completed period.
- PCNT  output  CW  completed periods since the last LOAD; saturates at all-ones.

Behaviour:
- Reset (CR low, asynchronous):
  - State goes to IDLE; mod_r=0 (meaning 16), PCNT=0, PERIOD=0.
  - Outputs during reset: PE=1, CEP=0, CET=0, D=0, BUSY=0.
- Preset: D = 16 - N computed in 4 bits, i.e. D = (~mod_r)+1 mod 16. N=16 gives D=0; N=1 gives D=15.
- States, with combinational outputs decoded from state and Q_IN:
  - IDLE: PE=1, CEP=0, CET=0.
  - LOAD: PE=0, CEP=0, CET=0.
  - RUN: CEP=1, CET=1; PE = 0 when Q_IN==4'hF, else 1.
  - HOLD: PE=1, CEP=0, CET=1.
- Transitions, priority STOP > PAUSE > others:
  - IDLE -> LOAD when START=1 and STOP=0. mod_r<=MOD and PCNT<=0 on that edge.
  - LOAD -> RUN after exactly one cycle; PAUSE is ignored in LOAD, STOP is not.
  - RUN -> HOLD when PAUSE=1.
  - HOLD -> RUN when PAUSE=0.
  - RUN or HOLD -> IDLE when STOP=1.
  - START while not in IDLE is ignored; MOD changes while BUSY are ignored.
- Period and reload mechanics:
  - In RUN with Q_IN==15, PE=0 makes the counter reload D instead of wrapping.
  - The counter therefore visits D..15: exactly N states per period.
  - N=1 means PE=0 every RUN cycle, so Q stays at 15.
- Period reporting:
  - A period completes on any edge where state==RUN and Q_IN==15.
  - On that edge: PERIOD<=1 and PCNT<=PCNT+1, saturating at 2^CW-1. Otherwise PERIOD<=0.
  - PERIOD is high for the cycle after the reload edge (latency 1).
- Simultaneous events:
  - STOP on a reload edge: the period is still counted and PERIOD still pulses, then the state goes to IDLE.
  - START and STOP together in IDLE: the block stays in IDLE.
  - PAUSE on a reload edge: the reload completes and the period counts; the state then moves to HOLD.
- The controller never reads TC; the modulus is enforced solely through Q_IN and PE.
- PCNT and PERIOD hold their values in IDLE. PERIOD clears after one cycle as normal.

Test Plan:
- Reset then MOD=10, START pulse -> D=6; one LOAD cycle with PE=0; Q_IN sequence 6..15 repeats every 10 cycles; PERIOD pulses every 10 cycles; PCNT=3 after 30 RUN cycles.
- MOD=0 (16) and MOD=1 -> D=0, period 16 cycles; D=15, PE=0 every RUN cycle, PERIOD high continuously, PCNT increments every cycle.
- PAUSE high for 5 cycles mid-period at Q=9 -> CEP=0, CET=1, Q stays 9; after release counting resumes; the period lengthens by exactly 5 cycles.
- STOP asserted on the edge where Q_IN=15 in RUN -> PERIOD pulses once, PCNT increments, BUSY=0 next cycle, and a later START with MOD=4 clears PCNT and loads D=12.
- CW=2, MOD=2, run 10 periods -> PCNT saturates at 3 and stays there.
- CR pulsed low mid-RUN at Q=11 -> BUSY, PERIOD and PCNT go to 0 immediately; PE=1, CEP=CET=0; no reload on the next edge.

Source files
------------

// File: rtl/cnt_modctl.sv
// cnt_modctl: control stage for an x74161-style 4-bit presettable counter.
// It drives PE/CEP/CET/D and watches Q so the pair divides by N (1..16).
// It supports start, stop and pause, pulses PERIOD once per completed
// period, and keeps a saturating count of completed periods in PCNT.
module cnt_modctl #(
  parameter int CW = 8
) (
  input  logic          CP,
  input  logic          CR,
  input  logic          START,
  input  logic          STOP,
  input  logic          PAUSE,
  input  logic [3:0]    MOD,
  input  logic [3:0]    Q_IN,
  output logic          PE,
  output logic          CEP,
  output logic          CET,
  output logic [3:0]    D,
  output logic          BUSY,
  output logic          PERIOD,
  output logic [CW-1:0] PCNT
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  logic [1:0]    state_q,  state_d;
  logic [3:0]    mod_q,    mod_d;
  logic [CW-1:0] pcnt_q,   pcnt_d;
  logic          period_q, period_d;
  logic          wrap_s;

  // Saturating increment: the count sticks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CW'(1'b1);
    end
  endfunction

  // A period completes whenever the counter is at 15 while running;
  // that is also the edge on which PE=0 makes the counter reload.
  assign wrap_s = (state_q == ST_RUN) && (Q_IN == 4'hF);

  // Preset is 16-N in 4 bits; mod_q=0 stands for N=16 and yields D=0.
  assign D      = (~mod_q) + 4'd1;
  assign BUSY   = (state_q != ST_IDLE);
  assign PERIOD = period_q;
  assign PCNT   = pcnt_q;

  // Decode the counter control lines from the current state and Q_IN.
  always_comb begin
    PE  = 1'b1;
    CEP = 1'b0;
    CET = 1'b0;
    case (state_q)
      ST_IDLE: begin
        PE  = 1'b1;
        CEP = 1'b0;
        CET = 1'b0;
      end
      ST_LOAD: begin
        PE  = 1'b0;
        CEP = 1'b0;
        CET = 1'b0;
      end
      ST_RUN: begin
        PE  = (Q_IN == 4'hF) ? 1'b0 : 1'b1;
        CEP = 1'b1;
        CET = 1'b1;
      end
      ST_HOLD: begin
        PE  = 1'b1;
        CEP = 1'b0;
        CET = 1'b1;
      end
      default: begin
        PE  = 1'b1;
        CEP = 1'b0;
        CET = 1'b0;
      end
    endcase
  end

  // Next-state, modulus capture and period bookkeeping (STOP beats PAUSE).
  always_comb begin
    state_d  = state_q;
    mod_d    = mod_q;
    pcnt_d   = pcnt_q;
    period_d = 1'b0;

    if (wrap_s) begin
      period_d = 1'b1;
      pcnt_d   = sat_inc(pcnt_q);
    end else begin
      period_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (START && !STOP) begin
          state_d = ST_LOAD;
          mod_d   = MOD;
          pcnt_d  = {CW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (STOP) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (STOP) begin
          state_d = ST_IDLE;
        end else if (PAUSE) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HOLD: begin
        if (STOP) begin
          state_d = ST_IDLE;
        end else if (!PAUSE) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      state_q  <= ST_IDLE;
      mod_q    <= 4'd0;
      pcnt_q   <= {CW{1'b0}};
      period_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mod_q    <= mod_d;
      pcnt_q   <= pcnt_d;
      period_q <= period_d;
    end
  end

endmodule

// File: tb/tb_cnt_modctl.sv
// Bench for cnt_modctl: two instances (CW=8 and CW=2) drive a shared
// x74161-style counter model; a spec-level model is compared every cycle,
// and directed scenarios add hand-computed literal expectations.
module tb_cnt_modctl;

  logic       CP = 1'b0;
  logic       CR = 1'b0;
  logic       START = 1'b0, STOP = 1'b0, PAUSE = 1'b0;
  logic [3:0] MOD = 4'd0;
  logic [3:0] q = 4'd0;

  logic       pe8, cep8, cet8, busy8, per8;
  logic [3:0] d8;
  logic [7:0] pcnt8;
  logic       pe2, cep2, cet2, busy2, per2;
  logic [3:0] d2;
  logic [1:0] pcnt2;

  int n_chk  = 0;
  int n_fail = 0;
  int len;

  cnt_modctl #(.CW(8)) dut8 (
    .CP(CP), .CR(CR), .START(START), .STOP(STOP), .PAUSE(PAUSE), .MOD(MOD),
    .Q_IN(q), .PE(pe8), .CEP(cep8), .CET(cet8), .D(d8), .BUSY(busy8),
    .PERIOD(per8), .PCNT(pcnt8));

  cnt_modctl #(.CW(2)) dut2 (
    .CP(CP), .CR(CR), .START(START), .STOP(STOP), .PAUSE(PAUSE), .MOD(MOD),
    .Q_IN(q), .PE(pe2), .CEP(cep2), .CET(cet2), .D(d2), .BUSY(busy2),
    .PERIOD(per2), .PCNT(pcnt2));

  always #5 CP = ~CP;

  // External 4-bit presettable counter, controlled by the CW=8 instance.
  always @(posedge CP) begin
    if (!pe8) q <= d8;
    else if (cep8 && cet8) q <= q + 4'd1;
  end

  // Spec-level reference: activity flags, modulus N and a plain period count.
  bit m_busy = 1'b0, m_load = 1'b0, m_hold = 1'b0, m_period = 1'b0;
  int m_n = 16;
  int m_pcnt = 0;
  wire m_wrap = m_busy && !m_load && !m_hold && (q == 4'd15);

  always @(posedge CP or negedge CR) begin
    if (!CR) begin
      m_busy <= 1'b0; m_load <= 1'b0; m_hold <= 1'b0;
      m_n <= 16; m_pcnt <= 0; m_period <= 1'b0;
    end else begin
      m_period <= m_wrap;
      if (m_wrap) m_pcnt <= m_pcnt + 1;
      if (!m_busy) begin
        if (START && !STOP) begin
          m_busy <= 1'b1; m_load <= 1'b1; m_hold <= 1'b0;
          m_n <= (MOD == 4'd0) ? 16 : int'(MOD);
          m_pcnt <= 0;
        end
      end else if (STOP) begin
        m_busy <= 1'b0; m_load <= 1'b0; m_hold <= 1'b0;
      end else if (m_load) begin
        m_load <= 1'b0;
      end else begin
        m_hold <= PAUSE;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the reference.
  always @(negedge CP) begin
    logic e_pe, e_cep, e_cet;
    int   e_d;
    e_pe  = !m_busy ? 1'b1 : m_load ? 1'b0 : m_hold ? 1'b1 : (q != 4'd15);
    e_cep = m_busy && !m_load && !m_hold;
    e_cet = m_busy && !m_load;
    e_d   = (16 - m_n) % 16;
    chk("m_pe8", 32'(pe8), 32'(e_pe));
    chk("m_cep8", 32'(cep8), 32'(e_cep));
    chk("m_cet8", 32'(cet8), 32'(e_cet));
    chk("m_d8", 32'(d8), 32'(e_d));
    chk("m_busy8", 32'(busy8), 32'(m_busy));
    chk("m_period8", 32'(per8), 32'(m_period));
    chk("m_pcnt8", 32'(pcnt8), 32'((m_pcnt > 255) ? 255 : m_pcnt));
    chk("m_pe2", 32'(pe2), 32'(e_pe));
    chk("m_busy2", 32'(busy2), 32'(m_busy));
    chk("m_d2", 32'(d2), 32'(e_d));
    chk("m_period2", 32'(per2), 32'(m_period));
    chk("m_pcnt2", 32'(pcnt2), 32'((m_pcnt > 3) ? 3 : m_pcnt));
  end

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  // Ticks until PERIOD pulses (bounded); returns the number of ticks taken.
  task automatic wait_period(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!per8 && n < 40);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_pe", 32'(pe8), 32'd1);
    chk("rst_cep", 32'(cep8), 32'd0);
    chk("rst_cet", 32'(cet8), 32'd0);
    chk("rst_d", 32'(d8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_pcnt", 32'(pcnt8), 32'd0);
    #10;
    CR = 1'b1;

    // Modulus 10: D=6, one LOAD cycle, Q walks 6..15
    MOD = 4'd10; START = 1'b1;
    tick();
    chk("load_d", 32'(d8), 32'd6);
    chk("load_pe", 32'(pe8), 32'd0);
    chk("load_busy", 32'(busy8), 32'd1);
    START = 1'b0;
    tick();
    chk("run_cep", 32'(cep8), 32'd1);
    for (int i = 0; i < 30; i++) begin
      chk("seq_q", 32'(q), 32'(6 + (i % 10)));
      tick();
    end
    chk("pcnt_after30", 32'(pcnt8), 32'd3);
    chk("period_after30", 32'(per8), 32'd1);

    // PAUSE for 5 cycles with Q held at 9; period grows from 10 to 15
    tick(); tick();
    chk("pre_pause_q", 32'(q), 32'd8);
    PAUSE = 1'b1;
    tick();
    chk("hold_q", 32'(q), 32'd9);
    chk("hold_cep", 32'(cep8), 32'd0);
    chk("hold_cet", 32'(cet8), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_q_stay", 32'(q), 32'd9);
    end
    PAUSE = 1'b0;
    tick();
    chk("resume_q", 32'(q), 32'd9);
    chk("resume_cep", 32'(cep8), 32'd1);
    wait_period(len);
    chk("paused_period_len", 32'(len + 8), 32'd15);
    chk("pcnt_after_pause", 32'(pcnt8), 32'd4);

    // STOP on the reload edge: period still counted, then IDLE
    repeat (9) tick();
    chk("stop_pre_q", 32'(q), 32'd15);
    STOP = 1'b1;
    tick();
    chk("stop_period", 32'(per8), 32'd1);
    chk("stop_pcnt", 32'(pcnt8), 32'd5);
    chk("stop_busy", 32'(busy8), 32'd0);
    STOP = 1'b0;
    tick();
    chk("idle_period", 32'(per8), 32'd0);
    chk("idle_pcnt", 32'(pcnt8), 32'd5);

    // START together with STOP in IDLE stays IDLE; then START with modulus 4
    MOD = 4'd4; START = 1'b1; STOP = 1'b1;
    tick();
    chk("startstop_busy", 32'(busy8), 32'd0);
    STOP = 1'b0;
    tick();
    chk("mod4_d", 32'(d8), 32'd12);
    chk("mod4_pcnt", 32'(pcnt8), 32'd0);
    START = 1'b0;
    tick();
    chk("mod4_q", 32'(q), 32'd12);
    STOP = 1'b1; tick(); STOP = 1'b0;

    // Modulus code 0 means divide by 16
    MOD = 4'd0; START = 1'b1;
    tick();
    chk("mod16_d", 32'(d8), 32'd0);
    START = 1'b0;
    tick();
    wait_period(len);
    chk("mod16_len_a", 32'(len), 32'd16);
    wait_period(len);
    chk("mod16_len_b", 32'(len), 32'd16);
    STOP = 1'b1; tick(); STOP = 1'b0;

    // Modulus 1: Q parks at 15, PE low every RUN cycle, PERIOD continuous
    MOD = 4'd1; START = 1'b1;
    tick();
    chk("mod1_d", 32'(d8), 32'd15);
    START = 1'b0;
    tick();
    chk("mod1_q", 32'(q), 32'd15);
    chk("mod1_pe", 32'(pe8), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("mod1_period", 32'(per8), 32'd1);
      chk("mod1_pcnt", 32'(pcnt8), 32'(k));
      chk("mod1_q_stay", 32'(q), 32'd15);
    end
    STOP = 1'b1; tick(); STOP = 1'b0;

    // Modulus 2 for 10 periods: CW=2 instance saturates at 3
    MOD = 4'd2; START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    chk("mod2_q", 32'(q), 32'd14);
    repeat (20) tick();
    chk("sat_pcnt8", 32'(pcnt8), 32'd10);
    chk("sat_pcnt2", 32'(pcnt2), 32'd3);
    STOP = 1'b1; tick(); STOP = 1'b0;

    // CR pulsed low mid-RUN at Q=11
    MOD = 4'd10; START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    repeat (15) tick();
    chk("prerst_q", 32'(q), 32'd11);
    chk("prerst_pcnt", 32'(pcnt8), 32'd1);
    #2;
    CR = 1'b0;
    #1;
    chk("arst_busy", 32'(busy8), 32'd0);
    chk("arst_period", 32'(per8), 32'd0);
    chk("arst_pcnt", 32'(pcnt8), 32'd0);
    chk("arst_pe", 32'(pe8), 32'd1);
    chk("arst_cep", 32'(cep8), 32'd0);
    chk("arst_cet", 32'(cet8), 32'd0);
    tick();
    chk("arst_q_hold", 32'(q), 32'd11);
    CR = 1'b1;
    tick();
    chk("post_rst_q", 32'(q), 32'd11);
    chk("post_rst_busy", 32'(busy8), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
